// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage: MEM->WB valid/ready stage with a 2-entry skid buffer, flush, hazard query and stall counter.
module mem_wb_skid_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int RA_W = 5,
  parameter int RSRC_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_read_data,
  input  logic [RA_W-1:0]       in_rd,
  input  logic [DATA_WIDTH-1:0] in_pc_plus4,
  input  logic                  in_reg_write,
  input  logic [RSRC_W-1:0]     in_result_src,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_alu_result,
  output logic [DATA_WIDTH-1:0] out_read_data,
  output logic [RA_W-1:0]       out_rd,
  output logic [DATA_WIDTH-1:0] out_pc_plus4,
  output logic                  out_reg_write,
  output logic [RSRC_W-1:0]     out_result_src,
  input  logic [RA_W-1:0]       q_rs1,
  input  logic [RA_W-1:0]       q_rs2,
  output logic                  q_hit1,
  output logic                  q_hit2,
  output logic [CNT_W-1:0]      stall_count
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] read_data;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [RA_W-1:0]       rd;
    logic                  reg_write;
    logic [RSRC_W-1:0]     result_src;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state;
  entry_t head, skid, cap;
  logic push, pop;
  // ready depends only on registered state, so MEM never sees a combinational path from WB
  assign in_ready = state != FULL;
  assign out_valid = state != EMPTY;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  always_comb begin
    cap.alu_result = in_alu_result;
    cap.read_data = in_read_data;
    cap.pc_plus4 = in_pc_plus4;
    cap.rd = in_rd;
    cap.reg_write = in_reg_write & (in_rd != '0);
    cap.result_src = in_result_src;
  end
  assign out_alu_result = head.alu_result;
  assign out_read_data = head.read_data;
  assign out_rd = head.rd;
  assign out_pc_plus4 = head.pc_plus4;
  assign out_reg_write = head.reg_write & out_valid;
  assign out_result_src = head.result_src;
  assign q_hit1 = (q_rs1 != '0) & ((out_valid & head.reg_write & (head.rd == q_rs1)) |
                  ((state == FULL) & skid.reg_write & (skid.rd == q_rs1)));
  assign q_hit2 = (q_rs2 != '0) & ((out_valid & head.reg_write & (head.rd == q_rs2)) |
                  ((state == FULL) & skid.reg_write & (skid.rd == q_rs2)));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      head <= '0;
      skid <= '0;
      stall_count <= '0;
    end else begin
      if (in_valid && !in_ready && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      if (flush) state <= EMPTY;
      else if (state == EMPTY) begin
        if (push) begin
          head <= cap;
          state <= ONE;
        end
      end else if (state == ONE) begin
        if (push && pop) head <= cap;
        else if (push) begin
          skid <= cap;
          state <= FULL;
        end else if (pop) state <= EMPTY;
      end else if (pop) begin
        head <= skid;
        state <= ONE;
      end
    end
  end
endmodule
